// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned DATA_W   = 8;

  typedef enum logic [3:0] {
    OP_A       = 4'd0,
    OP_B       = 4'd1,
    OP_NOT_A   = 4'd2,
    OP_NOT_B   = 4'd3,
    OP_ADD     = 4'd4,
    OP_ADD_INC = 4'd5,
    OP_INC_A   = 4'd6,
    OP_INC_B   = 4'd7,
    OP_SUB     = 4'd8,
    OP_DEC_B   = 4'd9,
    OP_NEG_A   = 4'd10,
    OP_AND     = 4'd11,
    OP_OR      = 4'd12,
    OP_ZERO    = 4'd13,
    OP_ONE     = 4'd14,
    OP_MINUS1  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] F_AND  = 2'b00;
  localparam logic [1:0] F_OR   = 2'b01;
  localparam logic [1:0] F_NOTB = 2'b10;
  localparam logic [1:0] F_ADD  = 2'b11;

  // cin holds CIN_lo in the decoded word and the live carry-in on the ALU bus
  typedef struct packed {
    logic       inva;
    logic       ena;
    logic       enb;
    logic [1:0] f;
    logic       cin;
  } ctrl_word_t;

  function automatic ctrl_word_t cw(input logic inva, input logic ena, input logic enb,
                                    input logic [1:0] f, input logic cin);
    ctrl_word_t w;
    w.inva = inva;
    w.ena  = ena;
    w.enb  = enb;
    w.f    = f;
    w.cin  = cin;
    return w;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode to bitalu_4 control-word decoder.
module alu_ctrl_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0]  op_code,
  output ctrl_word_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    unique case (opcode_e'(op_code))
      OP_A:       ctrl_c = cw(1'b0, 1'b1, 1'b0, F_OR,   1'b0);
      OP_B:       ctrl_c = cw(1'b0, 1'b0, 1'b1, F_OR,   1'b0);
      OP_NOT_A:   ctrl_c = cw(1'b1, 1'b1, 1'b0, F_OR,   1'b0);
      OP_NOT_B:   ctrl_c = cw(1'b0, 1'b0, 1'b1, F_NOTB, 1'b0);
      OP_ADD:     ctrl_c = cw(1'b0, 1'b1, 1'b1, F_ADD,  1'b0);
      OP_ADD_INC: ctrl_c = cw(1'b0, 1'b1, 1'b1, F_ADD,  1'b1);
      OP_INC_A:   ctrl_c = cw(1'b0, 1'b1, 1'b0, F_ADD,  1'b1);
      OP_INC_B:   ctrl_c = cw(1'b0, 1'b0, 1'b1, F_ADD,  1'b1);
      OP_SUB:     ctrl_c = cw(1'b1, 1'b1, 1'b1, F_ADD,  1'b1);
      OP_DEC_B:   ctrl_c = cw(1'b1, 1'b0, 1'b1, F_ADD,  1'b0);
      OP_NEG_A:   ctrl_c = cw(1'b1, 1'b1, 1'b0, F_ADD,  1'b1);
      OP_AND:     ctrl_c = cw(1'b0, 1'b1, 1'b1, F_AND,  1'b0);
      OP_OR:      ctrl_c = cw(1'b0, 1'b1, 1'b1, F_OR,   1'b0);
      OP_ZERO:    ctrl_c = cw(1'b0, 1'b0, 1'b0, F_ADD,  1'b0);
      OP_ONE:     ctrl_c = cw(1'b0, 1'b0, 1'b0, F_ADD,  1'b1);
      OP_MINUS1:  ctrl_c = cw(1'b1, 1'b0, 1'b0, F_ADD,  1'b0);
      default:    ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/bitalu_4.sv
// 4-bit slice ALU: A'=(A&ENA)^INVA, B'=B&ENB; F1F0 selects AND/OR/NOT B/ADD.
module bitalu_4
  import alu_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                inva,
  input  logic                ena,
  input  logic                enb,
  input  logic                f0,
  input  logic                f1,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] result,
  output logic                cout
);

  logic [NIBBLE_W-1:0] a_eff;
  logic [NIBBLE_W-1:0] b_eff;
  logic [NIBBLE_W:0]   sum;

  always_comb begin
    a_eff  = (a & {NIBBLE_W{ena}}) ^ {NIBBLE_W{inva}};
    b_eff  = b & {NIBBLE_W{enb}};
    sum    = (NIBBLE_W+1)'(a_eff) + (NIBBLE_W+1)'(b_eff) + (NIBBLE_W+1)'(cin);
    result = '0;
    cout   = 1'b0;
    unique case ({f1, f0})
      2'b00:   result = a_eff & b_eff;
      2'b01:   result = a_eff | b_eff;
      2'b10:   result = ~b_eff;
      default: {cout, result} = sum;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Sequences an 8-bit operation through an external 4-bit bitalu_4, low nibble first.
// Optional ALU_SEQ_FLAGS_EN adds registered res_zero/res_neg outputs.
module alu_nibble_seq
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [3:0]          op_code,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic                res_cout,
  output logic [NIBBLE_W-1:0] alu_a,
  output logic [NIBBLE_W-1:0] alu_b,
  output logic                alu_inva,
  output logic                alu_ena,
  output logic                alu_enb,
  output logic                alu_f0,
  output logic                alu_f1,
  output logic                alu_cin,
  input  logic [NIBBLE_W-1:0] alu_result,
  input  logic                alu_cout
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                res_zero,
  output logic                res_neg
`endif
);

  state_e              state_q, state_d;
  ctrl_word_t          dec_c;
  ctrl_word_t          ctrl_q, ctrl_d;
  ctrl_word_t          word_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   data_d;
  logic [NIBBLE_W-1:0] alu_a_d, alu_b_d;
  logic                carry_q, carry_d;
  logic                cout_d, valid_d, ready_d;

  alu_ctrl_decode u_decode (
    .op_code (op_code),
    .ctrl_c  (dec_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ALU bus values are computed one state ahead so the slice sees them for the whole state
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    data_d  = res_data;
    cout_d  = res_cout;
    valid_d = res_valid;
    word_d  = '0;
    alu_a_d = '0;
    alu_b_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          ctrl_d  = dec_c;
          a_d     = op_a;
          b_d     = op_b;
          word_d  = dec_c;
          alu_a_d = op_a[NIBBLE_W-1:0];
          alu_b_d = op_b[NIBBLE_W-1:0];
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        data_d     = {res_data[DATA_W-1:NIBBLE_W], alu_result};
        carry_d    = (ctrl_q.f == F_ADD) ? alu_cout : 1'b0;
        word_d     = ctrl_q;
        word_d.cin = carry_d;
        alu_a_d    = a_q[DATA_W-1:NIBBLE_W];
        alu_b_d    = b_q[DATA_W-1:NIBBLE_W];
        state_d    = ST_HI;
      end
      ST_HI: begin
        data_d  = {alu_result, res_data[NIBBLE_W-1:0]};
        cout_d  = (ctrl_q.f == F_ADD) ? alu_cout : 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        valid_d = 1'b1;
        if (res_valid && res_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_valid <= 1'b0;
      op_ready  <= 1'b1;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_inva  <= 1'b0;
      alu_ena   <= 1'b0;
      alu_enb   <= 1'b0;
      alu_f0    <= 1'b0;
      alu_f1    <= 1'b0;
      alu_cin   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      res_data  <= data_d;
      res_cout  <= cout_d;
      res_valid <= valid_d;
      op_ready  <= ready_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_inva  <= word_d.inva;
      alu_ena   <= word_d.ena;
      alu_enb   <= word_d.enb;
      alu_f0    <= word_d.f[0];
      alu_f1    <= word_d.f[1];
      alu_cin   <= word_d.cin;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_zero <= 1'b0;
      res_neg  <= 1'b0;
    end else begin
      res_zero <= (data_d == '0);
      res_neg  <= data_d[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed self-checking bench for alu_nibble_seq driving a bitalu_4 slice.
module tb_alu_nibble_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_ready, res_valid, res_ready, res_cout;
  logic [3:0] op_code;
  logic [7:0] op_a, op_b, res_data;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin, alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic       res_zero, res_neg;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       c;
  } vec_t;

  always #5 clk = ~clk;

  alu_nibble_seq dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cout(res_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_inva(alu_inva), .alu_ena(alu_ena), .alu_enb(alu_enb),
    .alu_f0(alu_f0), .alu_f1(alu_f1), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  bitalu_4 u_alu (
    .a(alu_a), .b(alu_b), .inva(alu_inva), .ena(alu_ena), .enb(alu_enb),
    .f0(alu_f0), .f1(alu_f1), .cin(alu_cin), .result(alu_result), .cout(alu_cout)
  );

  wire [13:0] alu_bus = {alu_a, alu_b, alu_inva, alu_ena, alu_enb, alu_f0, alu_f1, alu_cin};

  // Issue one op, scramble inputs after the handshake, count edges to res_valid
  task automatic run_op(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                        input bit accept, output logic [7:0] data, output logic cout,
                        output int lat);
    int wait_n;
    @(negedge clk);
    op_code  = code;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    wait_n   = 0;
    while (op_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = ~code;
    op_a     = ~a;
    op_b     = ~b;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = res_data;
    cout = res_cout;
    if (accept) begin
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    op_valid = 1'b0; res_ready = 1'b0;
    op_code = 4'd0; op_a = 8'h00; op_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({res_valid, res_data, res_cout} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid/data/cout got %b/%h/%b want 0/00/0", res_valid, res_data, res_cout);
    end
    checks++;
    if (alu_bus !== 14'd0) begin
      failures++;
      $display("FAIL reset_alu_bus: got %h want 0000", alu_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_op_ready: got %b want 1", op_ready);
    end
  endtask

  task automatic test_vectors;
    vec_t v[$];
    logic [7:0] d;
    logic c;
    int lat;
    v.push_back('{4'd4,  8'h3F, 8'h01, 8'h40, 1'b0});
    v.push_back('{4'd4,  8'hFF, 8'h01, 8'h00, 1'b1});
    v.push_back('{4'd8,  8'h03, 8'h05, 8'h02, 1'b1});
    v.push_back('{4'd8,  8'h05, 8'h03, 8'hFE, 1'b0});
    v.push_back('{4'd10, 8'h0A, 8'h77, 8'hF6, 1'b0});
    v.push_back('{4'd15, 8'h12, 8'h34, 8'hFF, 1'b0});
    v.push_back('{4'd14, 8'h12, 8'h34, 8'h01, 1'b0});
    v.push_back('{4'd11, 8'hA5, 8'h0F, 8'h05, 1'b0});
    v.push_back('{4'd12, 8'hA5, 8'h0F, 8'hAF, 1'b0});
    v.push_back('{4'd0,  8'hA5, 8'h3C, 8'hA5, 1'b0});
    v.push_back('{4'd1,  8'hA5, 8'h3C, 8'h3C, 1'b0});
    v.push_back('{4'd2,  8'hA5, 8'h3C, 8'h5A, 1'b0});
    v.push_back('{4'd3,  8'hA5, 8'h3C, 8'hC3, 1'b0});
    v.push_back('{4'd5,  8'h80, 8'h7F, 8'h00, 1'b1});
    v.push_back('{4'd6,  8'hFF, 8'h00, 8'h00, 1'b1});
    v.push_back('{4'd7,  8'h00, 8'h0F, 8'h10, 1'b0});
    v.push_back('{4'd9,  8'h00, 8'h10, 8'h0F, 1'b1});
    v.push_back('{4'd13, 8'hFF, 8'hFF, 8'h00, 1'b0});
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b1, d, c, lat);
      checks++;
      if (lat != 3) begin
        failures++;
        $display("FAIL latency op%0d: got %0d edges want 3", v[i].op, lat);
      end
      checks++;
      if ({d, c} !== {v[i].d, v[i].c}) begin
        failures++;
        $display("FAIL result op%0d a=%h b=%h: got %h/%b want %h/%b",
                 v[i].op, v[i].a, v[i].b, d, c, v[i].d, v[i].c);
      end
`ifdef ALU_SEQ_FLAGS_EN
      checks++;
      if ({res_zero, res_neg} !== {v[i].d == 8'h00, v[i].d[7]}) begin
        failures++;
        $display("FAIL flags op%0d: got z=%b n=%b want z=%b n=%b",
                 v[i].op, res_zero, res_neg, v[i].d == 8'h00, v[i].d[7]);
      end
`endif
      checks++;
      if ({res_valid, op_ready} !== 2'b01) begin
        failures++;
        $display("FAIL accept op%0d: valid/ready got %b%b want 01", v[i].op, res_valid, op_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] d;
    logic c;
    int lat;
    bit started;
    run_op(4'd5, 8'h12, 8'h34, 1'b0, d, c, lat);
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd14; op_a = 8'h55; op_b = 8'h66;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_data, res_cout, op_ready} !== {1'b1, 8'h47, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold cycle%0d: valid/data/cout/ready got %b/%h/%b/%b want 1/47/0/0",
                 k, res_valid, res_data, res_cout, op_ready);
      end
    end
    checks++;
    if (alu_bus !== 14'd0) begin
      failures++;
      $display("FAIL done_alu_bus: got %h want 0000", alu_bus);
    end
    @(negedge clk);
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    started = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0 || op_ready !== 1'b1) started = 1'b1;
    end
    checks++;
    if (started) begin
      failures++;
      $display("FAIL ignored_op: a request made during DONE produced activity, got 1 want 0");
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] d;
    logic c;
    int lat;
    bit seen;
    @(negedge clk);
    op_code = 4'd4; op_a = 8'h3F; op_b = 8'h01; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({op_ready, res_valid, alu_bus} !== {1'b1, 1'b0, 14'd0}) begin
      failures++;
      $display("FAIL rst_in_hi: ready/valid/bus got %b/%b/%h want 1/0/0000", op_ready, res_valid, alu_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (res_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_discard: res_valid pulse got 1 want 0");
    end
    run_op(4'd4, 8'h3F, 8'h01, 1'b1, d, c, lat);
    checks++;
    if ({d, c, lat[3:0]} !== {8'h40, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL rst_recover: data/cout/lat got %h/%b/%0d want 40/0/3", d, c, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    logic c;
    int lat;
    run_op(4'd9, 8'hAA, 8'h00, 1'b1, d, c, lat);
    checks++;
    if ({d, c, lat[3:0]} !== {8'hFF, 1'b0, 4'd3}) begin
      failures++;
      $display("FAIL b2b_first: data/cout/lat got %h/%b/%0d want ff/0/3", d, c, lat);
    end
    run_op(4'd7, 8'hAA, 8'hFF, 1'b1, d, c, lat);
    checks++;
    if ({d, c, lat[3:0]} !== {8'h00, 1'b1, 4'd3}) begin
      failures++;
      $display("FAIL b2b_second: data/cout/lat got %h/%b/%0d want 00/1/3", d, c, lat);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
